// File: rtl/fft_frame_feeder.sv
// Front end for the corefft pipeline: picks one of NCH ADC channels per frame and
// forwards whole 2^NALL-sample frames with an in-frame index, in single-shot or continuous mode.
module fft_frame_feeder #(
    parameter int WIDTH   = 16,
    parameter int NALL    = 9,
    parameter int NCH     = 4,
    parameter int CHSEL_W = 2,
    parameter int DROP_W  = 16
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      din_en,
    input  logic [NCH*WIDTH-1:0]      din_ad,
    input  logic [CHSEL_W-1:0]        ch_sel,
    input  logic                      mode,
    input  logic                      arm,
    input  logic                      stop,
    output logic                      core_en,
    output logic signed [WIDTH-1:0]   core_data,
    output logic [NALL-1:0]           core_cnt,
    output logic [CHSEL_W-1:0]        core_ch,
    output logic                      frame_start,
    output logic                      frame_done,
    output logic                      busy,
    output logic [DROP_W-1:0]         drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                mode_q, mode_d;
    logic                has_armed_q, has_armed_d;
    logic                stop_pend_q, stop_pend_d;
    logic [CHSEL_W-1:0]  ch_q, ch_d;
    logic [NALL-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                en_q, en_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic                accept;
    logic [NALL-1:0]     idx_next;
    logic                first_idx;
    logic                last_idx;
    logic [CHSEL_W-1:0]  ch_req;
    logic [CHSEL_W-1:0]  sel_ch;
    logic [WIDTH-1:0]    sample;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame only ends on its last index; stop merely decides whether another one follows.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && last_idx && (!mode_q || stop_pend_q || stop)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        busy   = 1'b0;
        unique case (state_q)
            ARMED: begin
                accept = din_en && !stop;
                busy   = 1'b1;
            end
            RUN: begin
                accept = din_en;
                busy   = 1'b1;
            end
            default: begin
                accept = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

    assign idx_next  = (state_q == RUN) ? cnt_q + 1'b1 : '0;
    assign first_idx = (idx_next == '0);
    assign last_idx  = &idx_next;

    // Out-of-range channel requests fall back to channel 0.
    assign ch_req = (int'(ch_sel) < NCH) ? ch_sel : '0;
    assign sel_ch = first_idx ? ch_req : ch_q;

    always_comb begin
        sample = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(sel_ch) == k) begin
                sample = din_ad[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        mode_d      = mode_q;
        has_armed_d = has_armed_q;
        stop_pend_d = stop_pend_q;
        if (state_q == IDLE && arm) begin
            mode_d      = mode;
            has_armed_d = 1'b1;
        end
        if (state_q != RUN) begin
            stop_pend_d = 1'b0;
        end else if (accept && last_idx) begin
            stop_pend_d = 1'b0;
        end else if (stop) begin
            stop_pend_d = 1'b1;
        end
    end

    // Data, index and channel hold while idle so the core always sees the last valid sample.
    always_comb begin
        en_d    = accept;
        start_d = accept && first_idx;
        done_d  = accept && last_idx;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        if (accept) begin
            data_d = sample;
            cnt_d  = idx_next;
            ch_d   = sel_ch;
        end
        drop_d = drop_q;
        if (state_q == IDLE && din_en && has_armed_q && !(&drop_q)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            mode_q      <= 1'b0;
            has_armed_q <= 1'b0;
            stop_pend_q <= 1'b0;
            ch_q        <= '0;
            cnt_q       <= '1;
            data_q      <= '0;
            en_q        <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= '0;
        end else begin
            mode_q      <= mode_d;
            has_armed_q <= has_armed_d;
            stop_pend_q <= stop_pend_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            en_q        <= en_d;
            start_q     <= start_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    assign core_en     = en_q;
    assign core_data   = data_q;
    assign core_cnt    = cnt_q;
    assign core_ch     = ch_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: a scoreboard queue holds every sample the
// bench expects the core to receive, and directed sequences cover arming, stop and reset.
module tb_fft_frame_feeder;

    localparam int WIDTH    = 16;
    localparam int NALL     = 9;
    localparam int NCH      = 4;
    localparam int CHSEL_W  = 3;
    localparam int DROP_W   = 4;
    localparam int FRAME    = 1 << NALL;
    localparam int LAST     = FRAME - 1;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                     clk;
    logic                     areset;
    logic                     din_en;
    logic [NCH*WIDTH-1:0]     din_ad;
    logic [CHSEL_W-1:0]       ch_sel;
    logic                     mode;
    logic                     arm;
    logic                     stop;
    logic                     core_en;
    logic signed [WIDTH-1:0]  core_data;
    logic [NALL-1:0]          core_cnt;
    logic [CHSEL_W-1:0]       core_ch;
    logic                     frame_start;
    logic                     frame_done;
    logic                     busy;
    logic [DROP_W-1:0]        drop_cnt;

    fft_frame_feeder #(
        .WIDTH(WIDTH), .NALL(NALL), .NCH(NCH), .CHSEL_W(CHSEL_W), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .areset(areset), .din_en(din_en), .din_ad(din_ad), .ch_sel(ch_sel),
        .mode(mode), .arm(arm), .stop(stop), .core_en(core_en), .core_data(core_data),
        .core_cnt(core_cnt), .core_ch(core_ch), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy), .drop_cnt(drop_cnt)
    );

    typedef struct {
        int   data;
        int   cnt;
        int   ch;
        logic start;
        logic done;
        int   cyc;
    } exp_t;

    typedef struct {
        logic [CHSEL_W-1:0] ch_sel;
        int                 exp_ch;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   en_seen    = 0;
    int   exp_drop   = 0;
    bit   has_armed  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Every core_en must match the head of the scoreboard, one cycle after its din_en.
    initial forever begin
        @(negedge clk);
        if (areset) begin
            if (core_en) begin
                en_seen++;
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_core_en", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("core_data", core_data, mon_e.data);
                    checkOutput("core_cnt", core_cnt, mon_e.cnt);
                    checkOutput("core_ch", core_ch, mon_e.ch);
                    checkOutput("start_done", {frame_start, frame_done}, {mon_e.start, mon_e.done});
                    checkOutput("latency_cycle", cyc, mon_e.cyc);
                end
            end else begin
                checkOutput("strobe_without_en", {frame_start, frame_done}, 0);
            end
        end
    end

    task automatic set_ad(input int n);
        for (int k = 0; k < NCH; k++) begin
            din_ad[k*WIDTH +: WIDTH] = WIDTH'(k * 1000 + n);
        end
    endtask

    task automatic applyStimulus(input logic en, input int n, input logic acc,
                                 input int ch, input int idx);
        exp_t e;
        set_ad(n);
        din_en = en;
        if (en && acc) begin
            e.data  = ch * 1000 + n;
            e.cnt   = idx;
            e.ch    = ch;
            e.start = (idx == 0);
            e.done  = (idx == LAST);
            e.cyc   = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        din_en = 1'b0;
        arm    = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", sbq.size(), 0);
    endtask

    task automatic idle_dins(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, 900 + i, 1'b0, 0, 0);
            if (has_armed) begin
                exp_drop = (exp_drop < DROP_MAX) ? exp_drop + 1 : DROP_MAX;
            end
        end
        drain();
        checkOutput("drop_cnt", drop_cnt, exp_drop);
        checkOutput("busy_idle", busy, 0);
    endtask

    task automatic do_arm(input logic m);
        mode = m;
        arm  = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 0, 0);
        has_armed = 1;
        checkOutput("busy_armed", busy, 1);
    endtask

    // Single-shot frame; a stray arm with mode=1 mid-frame must not turn it continuous.
    task automatic run_frame(input logic [CHSEL_W-1:0] sel, input int exp_ch);
        ch_sel = sel;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 50) begin
                arm  = 1'b1;
                mode = 1'b1;
            end
            applyStimulus(1'b1, i, 1'b1, exp_ch, i);
            if (i == LAST - 1) checkOutput("busy_in_frame", busy, 1);
        end
        checkOutput("busy_after_frame", busy, 0);
        mode = 1'b0;
    endtask

    task automatic check_reset_values();
        checkOutput("rst_core_en", core_en, 0);
        checkOutput("rst_core_data", core_data, 0);
        checkOutput("rst_core_cnt", core_cnt, LAST);
        checkOutput("rst_core_ch", core_ch, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   idx;
        int   en_before;

        vecs[0] = '{ch_sel: 3'd2, exp_ch: 2};
        vecs[1] = '{ch_sel: 3'd0, exp_ch: 0};
        vecs[2] = '{ch_sel: 3'd3, exp_ch: 3};
        vecs[3] = '{ch_sel: 3'd5, exp_ch: 0};
        vecs[4] = '{ch_sel: 3'd7, exp_ch: 0};
        vecs[5] = '{ch_sel: 3'd4, exp_ch: 0};

        areset = 1'b0;
        din_en = 1'b0;
        din_ad = '0;
        ch_sel = '0;
        mode   = 1'b0;
        arm    = 1'b0;
        stop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        areset = 1'b1;

        $display("[TB] idle before first arm: no drops, stop ignored");
        idle_dins(3);
        stop = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 0, 0);
        checkOutput("busy_after_idle_stop", busy, 0);

        $display("[TB] single-shot frames over channel table");
        for (int v = 0; v < 6; v++) begin
            do_arm(1'b0);
            run_frame(vecs[v].ch_sel, vecs[v].exp_ch);
            idle_dins(2);
        end

        $display("[TB] arm and din_en in the same idle cycle");
        mode = 1'b0;
        arm  = 1'b1;
        applyStimulus(1'b1, 7, 1'b0, 0, 0);
        exp_drop = (exp_drop < DROP_MAX) ? exp_drop + 1 : DROP_MAX;
        checkOutput("busy_after_arm_din", busy, 1);
        run_frame(3'd1, 1);
        drain();
        checkOutput("drop_cnt_arm_din", drop_cnt, exp_drop);

        $display("[TB] stop while armed");
        do_arm(1'b0);
        stop = 1'b1;
        applyStimulus(1'b1, 0, 1'b0, 0, 0);
        checkOutput("busy_after_armed_stop", busy, 0);
        idle_dins(1);

        $display("[TB] continuous: channel relatch, random gaps, stop");
        ch_sel = 3'd1;
        do_arm(1'b1);
        en_before = en_seen;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 200) ch_sel = 3'd3;
            applyStimulus(1'b1, i, 1'b1, 1, i);
        end
        idx = 0;
        while (idx < FRAME) begin
            if (idx == 0 || $urandom_range(0, 1) == 1) begin
                applyStimulus(1'b1, idx, 1'b1, 3, idx);
                idx++;
            end else begin
                applyStimulus(1'b0, idx, 1'b0, 0, 0);
            end
        end
        checkOutput("busy_between_frames", busy, 1);
        for (int i = 0; i < FRAME; i++) begin
            if (i == 100) stop = 1'b1;
            applyStimulus(1'b1, i, 1'b1, 3, i);
        end
        checkOutput("busy_after_stop_frame", busy, 0);
        idle_dins(2);
        checkOutput("core_en_total", en_seen - en_before, 3 * FRAME);

        $display("[TB] reset in the middle of a frame");
        ch_sel = 3'd2;
        do_arm(1'b1);
        for (int i = 0; i <= 300; i++) begin
            applyStimulus(1'b1, i, 1'b1, 2, i);
        end
        @(negedge clk);
        #1;
        areset = 1'b0;
        #1;
        check_reset_values();
        checkOutput("scoreboard_at_reset", sbq.size(), 0);
        sbq.delete();
        exp_drop  = 0;
        has_armed = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset = 1'b1;
        do_arm(1'b0);
        run_frame(3'd0, 0);
        drain();
        checkOutput("drop_cnt_after_reset", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
